// File: rtl/bcd_to_bin_seq.sv
// Three-digit BCD to 10-bit binary via reverse double-dabble; result 10 cycles after accepted start, err/done 1 cycle after for bad digits.
// No backpressure: start is taken only in IDLE and ignored (not queued) while converting or reporting.
module bcd_to_bin_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [9:0] binary,
    output logic       busy,
    output logic       done,
    output logic       err
);
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t      r_state;
    logic [11:0] r_bcd;
    logic [9:0]  r_bin;
    logic [3:0]  r_cnt;

    logic [11:0] w_bcd_sh;
    logic [11:0] w_bcd_nx;
    logic [9:0]  w_bin_nx;
    logic        w_bad;

    // A nibble >= 8 after the right shift carried in a half-ten; pull it back by 3.
    function automatic logic [3:0] fix_nib(input logic [3:0] n);
        return (n >= 4'd8) ? n - 4'd3 : n;
    endfunction

    assign w_bcd_sh = {1'b0, r_bcd[11:1]};
    assign w_bcd_nx = {fix_nib(w_bcd_sh[11:8]), fix_nib(w_bcd_sh[7:4]), fix_nib(w_bcd_sh[3:0])};
    assign w_bin_nx = {r_bcd[0], r_bin[9:1]};
    assign w_bad    = (hundreds > 4'd9) || (tens > 4'd9) || (ones > 4'd9);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_bcd   <= '0;
            r_bin   <= '0;
            r_cnt   <= '0;
            binary  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        if (w_bad) begin
                            binary  <= '0;
                            err     <= 1'b1;
                            done    <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_bcd   <= {hundreds, tens, ones};
                            r_bin   <= '0;
                            r_cnt   <= '0;
                            err     <= 1'b0;
                            busy    <= 1'b1;
                            r_state <= CONV;
                        end
                    end
                end
                CONV: begin
                    r_bcd <= w_bcd_nx;
                    r_bin <= w_bin_nx;
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd9) begin
                        binary  <= w_bin_nx;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
